// File: rtl/bram_memory_copy.sv
// BRAM copy engine: copies a pattern ROM into a simple dual-port RAM,
// then streams the RAM back out on data_out as a read-back check.
module bram_memory_copy #(
   parameter int DEPTH = 16,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter logic [DATA_W-1:0] SRC_BASE = 16'h1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [DATA_W-1:0] data_out,
   output logic              doneC,
   output logic              doneR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COPY,
      S_FLUSH,
      S_READ,
      S_RDRAIN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

   state_t state_q, state_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic we_q, we_d;
   logic rv_q, rv_d;
   logic [DATA_W-1:0] src_q, src_d;
   logic [DATA_W-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic donec_q, donec_d;
   logic doner_q, doner_d;

   logic [DATA_W-1:0] rom [DEPTH];
   logic [DATA_W-1:0] dst_mem [DEPTH];
   logic [ADDR_W-1:0] addr;

   // Source pattern is a constant table, wrapping modulo 2^DATA_W
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = SRC_BASE + DATA_W'(i);
   end

   assign addr = cnt_q[ADDR_W-1:0];

   // Next-state and datapath control for the copy / read-back sequence
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wa_d    = wa_q;
      we_d    = 1'b0;
      rv_d    = 1'b0;
      donec_d = donec_q;
      doner_d = doner_q;
      src_d   = rom[addr];
      dst_d   = dst_mem[addr];
      out_d   = rv_q ? dst_q : out_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_COPY;
               cnt_d   = '0;
               donec_d = 1'b0;
               doner_d = 1'b0;
            end
         end
         S_COPY: begin
            we_d  = 1'b1;
            wa_d  = addr;
            cnt_d = cnt_q + ONE;
            if (cnt_q == LAST) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end
         end
         S_FLUSH: begin
            donec_d = 1'b1;
            state_d = S_READ;
            cnt_d   = '0;
         end
         S_READ: begin
            rv_d  = 1'b1;
            cnt_d = cnt_q + ONE;
            if (cnt_q == LAST) begin
               state_d = S_RDRAIN;
               cnt_d   = '0;
            end
         end
         S_RDRAIN: begin
            doner_d = 1'b1;
            cnt_d   = cnt_q + ONE;
            if (cnt_q == ONE) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wa_q    <= '0;
         we_q    <= 1'b0;
         rv_q    <= 1'b0;
         out_q   <= '0;
         donec_q <= 1'b0;
         doner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wa_q    <= wa_d;
         we_q    <= we_d;
         rv_q    <= rv_d;
         out_q   <= out_d;
         donec_q <= donec_d;
         doner_q <= doner_d;
      end
   end

   // Memory read registers, never reset (BRAM output latches)
   always_ff @(posedge clk) begin
      src_q <= src_d;
      dst_q <= dst_d;
   end

   // Destination RAM write port; reset blocks a pending write
   always_ff @(posedge clk) begin
      if (we_q && !rst) begin
         dst_mem[wa_q] <= src_q;
      end
   end

   assign data_out = out_q;
   assign doneC    = donec_q;
   assign doneR    = doner_q;

endmodule

// File: tb/tb_bram_memory_copy.sv
// Directed bench for bram_memory_copy: default build plus a
// DEPTH=4 build whose source pattern wraps through zero.
module tb_bram_memory_copy;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic [15:0] dout0, dout1;
   logic dc0, dr0, dc1, dr1;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bram_memory_copy u0 (
      .clk(clk), .rst(rst), .start(start0),
      .data_out(dout0), .doneC(dc0), .doneR(dr0)
   );

   bram_memory_copy #(
      .DEPTH(4), .ADDR_W(2), .DATA_W(16), .SRC_BASE(16'hFFFE)
   ) u1 (
      .clk(clk), .rst(rst), .start(start1),
      .data_out(dout1), .doneC(dc1), .doneR(dr1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int which,
                          input logic [15:0] ed, input logic ec,
                          input logic er);
      if (which == 0) begin
         chk({tag, ".out"}, {16'h0, dout0}, {16'h0, ed});
         chk({tag, ".doneC"}, {31'h0, dc0}, {31'h0, ec});
         chk({tag, ".doneR"}, {31'h0, dr0}, {31'h0, er});
      end else begin
         chk({tag, ".out"}, {16'h0, dout1}, {16'h0, ed});
         chk({tag, ".doneC"}, {31'h0, dc1}, {31'h0, ec});
         chk({tag, ".doneR"}, {31'h0, dr1}, {31'h0, er});
      end
   endtask

   // One start pulse then a cycle-by-cycle check from E0 to E0+2D+4
   task automatic run(input string tag, input int which, input int depth,
                      input logic [15:0] base, input bit busy,
                      input logic [15:0] prev);
      logic [15:0] ed;
      if (which == 0) start0 = 1'b1;
      else start1 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
      chk_all($sformatf("%s.E0", tag), which, prev, 1'b0, 1'b0);
      for (int k = 1; k <= 2 * depth + 4; k++) begin
         if (busy && (k == 5 || k == 25)) start0 = 1'b1;
         tick();
         start0 = 1'b0;
         if (k < depth + 3) ed = prev;
         else if (k <= 2 * depth + 2) ed = base + 16'(k - depth - 3);
         else ed = base + 16'(depth - 1);
         chk_all($sformatf("%s.E%0d", tag, k), which, ed,
                 k >= depth + 1, k >= 2 * depth + 2);
      end
   endtask

   initial begin
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all("rst", 0, 16'h0, 1'b0, 1'b0);
      chk_all("rst1", 1, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_all($sformatf("idle%0d", i), 0, 16'h0, 1'b0, 1'b0);
      end

      run("basic", 0, 16, 16'h1000, 1'b0, 16'h0);
      repeat (3) tick();
      run("busy", 0, 16, 16'h1000, 1'b1, 16'h100F);
      repeat (2) tick();
      run("restart", 0, 16, 16'h1000, 1'b0, 16'h100F);

      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all("midrst", 0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_all($sformatf("midrst%0d", i), 0, 16'h0, 1'b0, 1'b0);
      end
      run("after_rst", 0, 16, 16'h1000, 1'b0, 16'h0);

      run("d4", 1, 4, 16'hFFFE, 1'b0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_memory_copy.md
# bram_memory_copy

Block-RAM copy engine: on a one-cycle `start` pulse it copies DEPTH words from an internal source ROM into an internal destination RAM, then streams the destination contents out on `data_out` as a read-back check. `doneC` flags copy completion and `doneR` flags read-back completion. It is a self-contained BRAM exercise block with no external memory ports.

## Interface
- DEPTH, 16, number of words copied; power of two, 2..256.
- ADDR_W, 4, address width; equals log2(DEPTH).
- DATA_W, 16, word width; `data_out` is 16 bits at the default.
- SRC_BASE, 16'h1000, source pattern base; src[i] = SRC_BASE + i, modulo 2^DATA_W.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin copy and read-back.
- data_out  out  DATA_W  registered read-back word.
- doneC  out  1  level; copy phase complete.
- doneR  out  1  level; read-back phase complete.

## Operation
- Source memory: ROM of DEPTH words holding src[i] = SRC_BASE + i. Synchronous read with 1-cycle latency.
- Destination memory: simple dual-port RAM of DEPTH words. Synchronous write; synchronous read with 1-cycle latency. No reset of contents.
- FSM states:
  - IDLE: waits for start.
  - COPY: issues source reads 0..DEPTH-1, one per cycle.
  - FLUSH: performs the last pipelined write.
  - READ: issues destination reads 0..DEPTH-1.
  - RDRAIN: two cycles that let the last word reach data_out.
  - DONE: holds the results.
- Transitions:
  - IDLE→COPY on start=1.
  - COPY→FLUSH after address DEPTH-1.
  - FLUSH→READ.
  - READ→RDRAIN after address DEPTH-1.
  - RDRAIN→DONE.
  - DONE→COPY on start=1. Re-run: doneC and doneR clear on the same edge.
- Copy pipeline: source data read at address c is written to dst[c] one cycle later. Write address and enable are delayed with the read.
- Read-back: the dst_q register feeds the data_out register, 2 cycles from address to data_out.
- start is ignored while in COPY, FLUSH, READ or RDRAIN.
- Counters are ADDR_W+1 bits wide so termination is detected without wrap ambiguity.
- Outputs before the first reset are don't-care; the bench applies reset first.

## Timing
Let E0 be the rising edge at which start=1 is sampled in IDLE or DONE.
- Copy phase:
  - Source address c is registered at E0+1+c.
  - dst[c] is written at edge E0+2+c, for c = 0..DEPTH-1.
  - The last write occurs at E0+DEPTH+1.
- doneC rises at E0+DEPTH+1, the same edge as the final write. It stays high until reset or the next accepted start.
- Read-back:
  - data_out = dst[r] from edge E0+DEPTH+3+r, for r = 0..DEPTH-1.
  - After the last word, data_out holds dst[DEPTH-1].
- doneR rises at E0+2·DEPTH+2, the same edge data_out takes its final word. It stays high until reset or the next accepted start.
- Default DEPTH=16: doneC at E0+17, first word at E0+19, doneR at E0+34.
- Reset, from any state:
  - State goes to IDLE; counters go to 0.
  - data_out=0, doneC=0, doneR=0 on the edge after rst is sampled high.
  - Destination RAM contents are unchanged.
- rst has priority over start in the same cycle.

## Test plan
- Reset then idle: rst high for 1 cycle, start low → data_out=0, doneC=0, doneR=0 held for 20+ cycles.
- Basic run: reset, then a 1-cycle start pulse 20 cycles later → doneC rises at E0+17. data_out sequence is 16'h1000..16'h100F at edges E0+19..E0+34. doneR rises at E0+34; data_out then holds 16'h100F.
- Busy start ignored: extra start pulses at E0+5 and E0+25 → timing and values identical to the basic run.
- Restart from DONE: second start after doneR → both done flags clear on the accepting edge, and the same sequence repeats with the same relative timing.
- Reset mid-copy: rst asserted at E0+8 → IDLE, all outputs 0, no done flags. A later start completes normally with the full 16'h1000..16'h100F sequence.
- Parameter sweep: DEPTH=4, SRC_BASE=16'hFFFE → read-back sequence FFFE, FFFF, 0000, 0001 (wraps modulo 2^DATA_W). doneC at E0+5, doneR at E0+10.
